serial_inc_seq: RTL and testbench

- Bit-serial sequencer for the team's 16-bit half-adder incrementer datapath.
- Computes y = a + 1 by stepping one shared half-adder cell across the operand, LSB first, one bit per clock.
- Start/done handshake, optional early termination once the carry dies, and overflow and cycle-count reporting.
- Used where the gate count of a full ripple chain is not affordable; the same half-adder gate structure is reused.

---
 rtl/serial_inc_seq_if.sv | 24 ++
 rtl/serial_inc_seq.sv | 101 ++++++++++
 tb/tb_serial_inc_seq.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_inc_seq_if.sv
// Handshake and data bundle for the bit-serial incrementer.
// The master side issues start/a and observes the result and status signals.
interface serial_inc_seq_if #(
    parameter int W  = 16,
    parameter int CW = $clog2(W) + 1
);
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  y;
    logic          done;
    logic          busy;
    logic          ovf;
    logic [CW-1:0] cycles;

    modport master (
        output start, a,
        input  y, done, busy, ovf, cycles
    );

    modport slave (
        input  start, a,
        output y, done, busy, ovf, cycles
    );
endinterface

// File: rtl/serial_inc_seq.sv
// Bit-serial incrementer: y = a + 1 computed LSB first with a single shared
// half-adder cell, one bit per clock. Optionally stops as soon as the carry
// dies, since the untouched upper bits of y already hold a.
module serial_inc_seq #(
    parameter int W          = 16,
    parameter bit EARLY_EXIT = 1'b1,
    parameter int CW         = $clog2(W) + 1
) (
    input  logic              clk,
    input  logic              rst,
    serial_inc_seq_if.slave   bus
);
    localparam int IW = $clog2(W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q,  state_d;
    logic [W-1:0]  y_q,      y_d;
    logic          carry_q,  carry_d;
    logic [IW-1:0] idx_q,    idx_d;
    logic [CW-1:0] cycles_q, cycles_d;
    logic          ovf_q,    ovf_d;

    // Shared half-adder cell, applied to the bit currently selected by idx.
    logic ha_in;
    logic ha_sum;
    logic ha_cout;
    logic last_bit;

    assign ha_in    = y_q[idx_q];
    assign ha_sum   = ha_in ^ carry_q;
    assign ha_cout  = ha_in & carry_q;
    assign last_bit = (idx_q == IW'(W - 1));

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d  = state_q;
        y_d      = y_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        cycles_d = cycles_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    y_d      = bus.a;
                    carry_d  = 1'b1;
                    idx_d    = '0;
                    cycles_d = '0;
                    ovf_d    = 1'b0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                y_d[idx_q] = ha_sum;
                carry_d    = ha_cout;
                cycles_d   = cycles_q + CW'(1);
                idx_d      = idx_q + IW'(1);
                if (last_bit || (EARLY_EXIT && !ha_cout)) begin
                    // Overflow only when the carry survives the top bit.
                    ovf_d   = last_bit & ha_cout;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            y_q      <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            cycles_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            y_q      <= y_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            cycles_q <= cycles_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.y      = y_q;
    assign bus.ovf    = ovf_q;
    assign bus.cycles = cycles_q;
    assign bus.busy   = (state_q == S_RUN);
    assign bus.done   = (state_q == S_DONE);

endmodule

// File: tb/tb_serial_inc_seq.sv
// Scoreboard bench for serial_inc_seq: one early-exit instance and one
// full-width instance share clock and reset.
module tb_serial_inc_seq;
    localparam int W  = 16;
    localparam int CW = $clog2(W) + 1;

    typedef struct {
        logic [W-1:0] y;
        logic         ovf;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    int total = 0;
    int bad   = 0;
    int dones1 = 0;
    int dones0 = 0;
    logic prev1 = 1'b0;
    logic prev0 = 1'b0;
    exp_t q1[$];
    exp_t q0[$];
    exp_t e1;
    exp_t e0;

    serial_inc_seq_if #(.W(W), .CW(CW)) b1 ();
    serial_inc_seq_if #(.W(W), .CW(CW)) b0 ();

    serial_inc_seq #(.W(W), .EARLY_EXIT(1'b1), .CW(CW)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    serial_inc_seq #(.W(W), .EARLY_EXIT(1'b0), .CW(CW)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Reference: a+1, overflow on all-ones, steps = trailing ones + 1 (capped) or W.
    function automatic exp_t model(input logic [W-1:0] a, input bit ee);
        exp_t r;
        int t;
        t = 0;
        while (t < W && a[t]) t++;
        r.y   = a + 16'd1;
        r.ovf = (a == {W{1'b1}});
        r.cyc = ee ? ((t + 1 > W) ? W : t + 1) : W;
        return r;
    endfunction

    // Result monitors: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && b1.done) begin
            dones1++;
            chk("d1_busy", {31'd0, b1.busy}, 0);
            chk("d1_width", {31'd0, prev1}, 0);
            if (q1.size() == 0) begin
                chk("d1_spurious", {31'd0, b1.done}, 0);
            end else begin
                e1 = q1.pop_front();
                chk("d1_y", {16'd0, b1.y}, {16'd0, e1.y});
                chk("d1_ovf", {31'd0, b1.ovf}, {31'd0, e1.ovf});
                chk("d1_cycles", {27'd0, b1.cycles}, e1.cyc);
            end
        end
        prev1 = b1.done;
    end

    always @(negedge clk) begin
        if (!rst && b0.done) begin
            dones0++;
            chk("d0_busy", {31'd0, b0.busy}, 0);
            chk("d0_width", {31'd0, prev0}, 0);
            if (q0.size() == 0) begin
                chk("d0_spurious", {31'd0, b0.done}, 0);
            end else begin
                e0 = q0.pop_front();
                chk("d0_y", {16'd0, b0.y}, {16'd0, e0.y});
                chk("d0_ovf", {31'd0, b0.ovf}, {31'd0, e0.ovf});
                chk("d0_cycles", {27'd0, b0.cycles}, e0.cyc);
            end
        end
        prev0 = b0.done;
    end

    // Count negedges until done is seen on the selected instance (bounded).
    task automatic wait_done(input bit sel, input int budget, output int lat);
        logic d;
        lat = 0;
        d = 1'b0;
        while (!d && lat < budget) begin
            @(negedge clk);
            lat++;
            d = sel ? b1.done : b0.done;
        end
        if (!d) chk("timeout", {31'd0, d}, 1);
    endtask

    // Single early-exit operation with latency and hold checks.
    task automatic do_op1(input logic [W-1:0] a);
        exp_t m;
        int lat;
        m = model(a, 1'b1);
        @(negedge clk);
        b1.a = a;
        b1.start = 1'b1;
        q1.push_back(m);
        @(negedge clk);
        b1.start = 1'b0;
        chk("op_busy", {31'd0, b1.busy}, 1);
        wait_done(1'b1, 40, lat);
        chk("op_lat", lat, m.cyc);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_done", {31'd0, b1.done}, 0);
            chk("hold_y", {16'd0, b1.y}, {16'd0, m.y});
        end
    endtask

    initial begin
        int lat;
        rst = 1'b1;
        b1.start = 1'b0; b1.a = '0;
        b0.start = 1'b0; b0.a = '0;
        repeat (3) @(negedge clk);
        chk("rst_y", {16'd0, b1.y}, 0);
        chk("rst_busy", {31'd0, b1.busy}, 0);
        chk("rst_done", {31'd0, b1.done}, 0);
        chk("rst_ovf", {31'd0, b1.ovf}, 0);
        chk("rst_cycles", {27'd0, b1.cycles}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", {31'd0, b0.busy}, 0);

        // Directed early-exit operations, including wrap-around.
        do_op1(16'd5000);
        do_op1(16'd5007);
        do_op1(16'hFFFF);
        do_op1(16'd0);

        // Full-width build, start held: one result every 18 cycles.
        @(negedge clk);
        b0.a = 16'd5000;
        q0.push_back(model(16'd5000, 1'b0));
        b0.start = 1'b1;
        wait_done(1'b0, 40, lat);
        chk("ee0_lat0", lat, 17);
        for (int i = 1; i < 30; i++) begin
            b0.a = 16'(5000 + i);
            q0.push_back(model(16'(5000 + i), 1'b0));
            wait_done(1'b0, 40, lat);
            chk("ee0_gap", lat, 18);
        end
        b0.start = 1'b0;
        repeat (20) @(negedge clk);

        // Early-exit build, start held: gap is n + 2.
        b1.a = 16'd5000;
        q1.push_back(model(16'd5000, 1'b1));
        b1.start = 1'b1;
        wait_done(1'b1, 40, lat);
        chk("ee1_lat0", lat, model(16'd5000, 1'b1).cyc + 1);
        for (int i = 1; i < 30; i++) begin
            b1.a = 16'(5000 + i);
            q1.push_back(model(16'(5000 + i), 1'b1));
            wait_done(1'b1, 40, lat);
            chk("ee1_gap", lat, model(16'(5000 + i), 1'b1).cyc + 2);
        end
        b1.start = 1'b0;
        repeat (20) @(negedge clk);

        // start and a changed mid-RUN must be ignored.
        b0.a = 16'h1234;
        b0.start = 1'b1;
        q0.push_back(model(16'h1234, 1'b0));
        @(negedge clk);
        b0.start = 1'b0;
        repeat (4) @(negedge clk);
        b0.a = 16'hFFFF;
        b0.start = 1'b1;
        @(negedge clk);
        b0.start = 1'b0;
        wait_done(1'b0, 40, lat);
        repeat (20) @(negedge clk);
        chk("ignore_y", {16'd0, b0.y}, 32'h1235);

        // Reset mid-RUN: immediate clear, no done afterwards.
        b0.a = 16'h00FF;
        b0.start = 1'b1;
        @(negedge clk);
        b0.start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_abort_busy", {31'd0, b0.busy}, 1);
        rst = 1'b1;
        #1;
        chk("abort_y", {16'd0, b0.y}, 0);
        chk("abort_busy", {31'd0, b0.busy}, 0);
        chk("abort_done", {31'd0, b0.done}, 0);
        chk("abort_ovf", {31'd0, b0.ovf}, 0);
        chk("abort_cycles", {27'd0, b0.cycles}, 0);
        chk("abort_y1", {16'd0, b1.y}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        do_op1(16'h7FFF);

        chk("q1_left", q1.size(), 0);
        chk("q0_left", q0.size(), 0);
        chk("n_done1", dones1, 35);
        chk("n_done0", dones0, 31);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
